// File: rtl/change_dispenser.sv
// Coin-change dispenser: latches a refund amount and drops coins one at a time,
// largest denomination first, through a valid/ack handshake with the coin hopper.
module change_dispenser #(
   parameter int COIN_VAL0   = 100,
   parameter int COIN_VAL1   = 500,
   parameter int COIN_VAL2   = 1000,
   parameter int TOTAL_BITS  = 31,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_start,
   input  logic [TOTAL_BITS-1:0] i_amount,
   input  logic                  i_coin_ack,
   output logic                  o_coin_valid,
   output logic [2:0]            o_coin_sel,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [TOTAL_BITS-1:0] o_remainder,
   output logic                  o_error,
   output logic [7:0]            o_coin_count
);

   localparam logic [TOTAL_BITS-1:0] V0 = TOTAL_BITS'(COIN_VAL0);
   localparam logic [TOTAL_BITS-1:0] V1 = TOTAL_BITS'(COIN_VAL1);
   localparam logic [TOTAL_BITS-1:0] V2 = TOTAL_BITS'(COIN_VAL2);
   localparam logic [7:0]            TMO_LAST = 8'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, SELECT, PRESENT, DONE} state_t;

   state_t                state, state_n;
   logic [TOTAL_BITS-1:0] remaining, remaining_n, remainder_n, coin_val;
   logic [7:0]            tmo_cnt, tmo_cnt_n, count_n;
   logic [2:0]            sel_n;
   logic                  valid_n, error_n;

   // Value of the coin currently presented, decoded from the held one-hot select.
   always_comb begin
      coin_val = V0;
      if (o_coin_sel[2])      coin_val = V2;
      else if (o_coin_sel[1]) coin_val = V1;
   end

   always_comb begin
      state_n     = state;
      remaining_n = remaining;
      tmo_cnt_n   = tmo_cnt;
      count_n     = o_coin_count;
      sel_n       = o_coin_sel;
      valid_n     = o_coin_valid;
      error_n     = o_error;
      remainder_n = o_remainder;
      case (state)
         IDLE: begin
            if (i_start) begin
               remaining_n = i_amount;
               count_n     = 8'd0;
               error_n     = 1'b0;
               state_n     = (i_amount < V0) ? DONE : SELECT;
            end
         end
         SELECT: begin
            if (remaining >= V2)      sel_n = 3'b100;
            else if (remaining >= V1) sel_n = 3'b010;
            else                      sel_n = 3'b001;
            valid_n   = 1'b1;
            tmo_cnt_n = 8'd0;
            state_n   = PRESENT;
         end
         PRESENT: begin
            // An ack in the final waiting cycle still counts: ack beats timeout.
            if (i_coin_ack) begin
               remaining_n = remaining - coin_val;
               if (o_coin_count != 8'hFF) count_n = o_coin_count + 8'd1;
               valid_n = 1'b0;
               state_n = (remaining_n < V0) ? DONE : SELECT;
            end else if (tmo_cnt == TMO_LAST) begin
               error_n = 1'b1;
               valid_n = 1'b0;
               state_n = DONE;
            end else begin
               tmo_cnt_n = tmo_cnt + 8'd1;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (state_n == DONE) remainder_n = remaining_n;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         remaining    <= '0;
         tmo_cnt      <= '0;
         o_coin_count <= '0;
         o_coin_sel   <= '0;
         o_coin_valid <= 1'b0;
         o_error      <= 1'b0;
         o_remainder  <= '0;
         o_done       <= 1'b0;
         o_busy       <= 1'b0;
      end else begin
         state        <= state_n;
         remaining    <= remaining_n;
         tmo_cnt      <= tmo_cnt_n;
         o_coin_count <= count_n;
         o_coin_sel   <= sel_n;
         o_coin_valid <= valid_n;
         o_error      <= error_n;
         o_remainder  <= remainder_n;
         o_done       <= (state_n == DONE);
         o_busy       <= (state_n != IDLE);
      end
   end

endmodule
